// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state encoding and CRC-16-CCITT constants for the configuration loader
package cfg_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_CHECK = 3'd2,
      S_SET   = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } cfg_state_e;

   localparam int               CRC_W    = 16;
   localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
   localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

   // One MSB-first CRC step for a single serial bit.
   function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc, input logic din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/cfg_crc16.sv
// rtl/cfg_crc16.sv - CRC-16-CCITT accumulator folding NUM_CHAINS bits per cycle, chain 0 first
module cfg_crc16
   import cfg_loader_pkg::*;
#(
   parameter int NUM_CHAINS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  en,
   input  logic [NUM_CHAINS-1:0] bits,
   output logic [CRC_W-1:0]      crc
);

   logic [CRC_W-1:0] crc_next;

   // Fold the slice in emission order: chain 0 is the oldest bit of the cycle.
   always_comb begin
      crc_next = crc;
      for (int k = 0; k < NUM_CHAINS; k++) begin
         crc_next = crc16_step(crc_next, bits[k]);
      end
   end

   // Accumulator restarts on reset and on every new load.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - bitstream word stream to parallel config shift chains; CRC check under CFG_LOADER_CRC_EN
module cfg_loader
   import cfg_loader_pkg::*;
#(
   parameter int NUM_CHAINS = 1,
   parameter int CHAIN_LEN  = 4768,
   parameter int WORD_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_W-1:0]     data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [NUM_CHAINS-1:0] cfg_shift,
   output logic                  cen,
   output logic                  cset,
   output logic                  en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int SLICES = WORD_W / NUM_CHAINS;
   localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);

   localparam logic [2:0] IDLE  = S_IDLE;
   localparam logic [2:0] SHIFT = S_SHIFT;
   localparam logic [2:0] SET   = S_SET;
   localparam logic [2:0] DONE  = S_DONE;
`ifdef CFG_LOADER_CRC_EN
   localparam logic [2:0] CHECK = S_CHECK;
   localparam logic [2:0] ERR   = S_ERR;
   localparam logic [2:0] AFTER_SHIFT = CHECK;
`else
   localparam logic [2:0] AFTER_SHIFT = SET;
`endif

   if (NUM_CHAINS < 1 || WORD_W % NUM_CHAINS != 0) begin : g_bad_word_w
      $error("cfg_loader: WORD_W must be a non-zero multiple of NUM_CHAINS");
   end
   if (CHAIN_LEN < 1) begin : g_bad_chain_len
      $error("cfg_loader: CHAIN_LEN must be at least 1");
   end

   logic [2:0]        state;
   logic [WORD_W-1:0] buf_data;
   logic              buf_full;
   logic [SL_W-1:0]   slice_idx;
   logic [CNT_W-1:0]  shift_cnt;

   logic in_shift, emit, last_slice, final_emit, word_done, start_ok, accept;

   assign in_shift   = (state == SHIFT);
   assign emit       = in_shift && buf_full;
   assign last_slice = (slice_idx == SL_W'(SLICES - 1));
   assign final_emit = emit && (shift_cnt == CNT_W'(CHAIN_LEN - 1));
   // Leftover slices of the final word are dropped, so the word ends early there.
   assign word_done  = emit && (last_slice || final_emit);
   assign accept     = data_valid && data_ready;

`ifdef CFG_LOADER_CRC_EN
   assign start_ok   = (state == IDLE) || (state == DONE) || (state == ERR);
   // The CRC word lands in CHECK, never in the shift buffer.
   assign data_ready = (in_shift && (!buf_full || (word_done && !final_emit))) || (state == CHECK);
   assign err        = (state == ERR);
`else
   assign start_ok   = (state == IDLE) || (state == DONE);
   assign data_ready = in_shift && (!buf_full || (word_done && !final_emit));
   assign err        = 1'b0;
`endif

   assign cen       = emit;
   assign cfg_shift = emit ? buf_data[NUM_CHAINS-1:0] : '0;
   assign cset      = (state == SET);
   assign done      = (state == DONE);
   assign en        = (state == DONE);
`ifdef CFG_LOADER_CRC_EN
   assign busy      = in_shift || (state == CHECK) || (state == SET);
`else
   assign busy      = in_shift || (state == SET);
`endif

`ifdef CFG_LOADER_CRC_EN
   logic [CRC_W-1:0] crc_val;
   logic [CRC_W-1:0] crc_rx;
   logic             crc_ok;

   cfg_crc16 #(.NUM_CHAINS(NUM_CHAINS)) u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (start && start_ok),
      .en    (emit),
      .bits  (cfg_shift),
      .crc   (crc_val)
   );

   if (WORD_W >= CRC_W) begin : g_rx_wide
      assign crc_rx = data_in[CRC_W-1:0];
   end else begin : g_rx_narrow
      assign crc_rx = CRC_W'(data_in);
   end

   assign crc_ok = (crc_rx == crc_val);
`endif

   // Load sequencing; start is only honoured between loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (start_ok) begin
         if (start) state <= SHIFT;
      end else begin
         case (state)
            SHIFT: if (final_emit) state <= AFTER_SHIFT;
`ifdef CFG_LOADER_CRC_EN
            CHECK: if (accept) state <= crc_ok ? SET : ERR;
`endif
            SET:     state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Single-word buffer drained one slice per cen cycle; a refill can overlap the last slice.
   always_ff @(posedge clk) begin
      if (rst || (start && start_ok)) begin
         buf_data  <= '0;
         buf_full  <= 1'b0;
         slice_idx <= '0;
         shift_cnt <= '0;
      end else begin
         if (in_shift && accept) begin
            buf_data  <= data_in;
            buf_full  <= 1'b1;
            slice_idx <= '0;
         end else if (word_done) begin
            buf_full  <= 1'b0;
            slice_idx <= '0;
         end else if (emit) begin
            buf_data  <= buf_data >> NUM_CHAINS;
            slice_idx <= slice_idx + SL_W'(1);
         end
         if (emit) shift_cnt <= shift_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - self-checking bench for cfg_loader, single-chain and four-chain configurations
module tb_cfg_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst = 1'b1;
   logic        start_a = 1'b0, dv_a = 1'b0, dr_a;
   logic [7:0]  din_a = '0;
   logic [0:0]  cs_a;
   logic        cen_a, cset_a, en_a, busy_a, done_a, err_a;

   logic        start_b = 1'b0, dv_b = 1'b0, dr_b;
   logic [31:0] din_b = '0;
   logic [3:0]  cs_b;
   logic        cen_b, cset_b, en_b, busy_b, done_b, err_b;

   cfg_loader #(.NUM_CHAINS(1), .CHAIN_LEN(10), .WORD_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .data_in(din_a), .data_valid(dv_a),
      .data_ready(dr_a), .cfg_shift(cs_a), .cen(cen_a), .cset(cset_a), .en(en_a),
      .busy(busy_a), .done(done_a), .err(err_a));

   cfg_loader #(.NUM_CHAINS(4), .CHAIN_LEN(8), .WORD_W(32)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .data_in(din_b), .data_valid(dv_b),
      .data_ready(dr_b), .cfg_shift(cs_b), .cen(cen_b), .cset(cset_b), .en(en_b),
      .busy(busy_b), .done(done_b), .err(err_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

`ifdef CFG_LOADER_CRC_EN
   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic [15:0] x;
      x = c ^ {b, 15'b0};
      return x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
   endfunction
`endif

   // Scoreboards: expected slices queued at stimulus time, popped on each cen cycle.
   logic       q_a[$];
   logic [3:0] q_b[$];
   int cen_cnt_a, cset_cnt_a, first_a, last_a, cset_cyc_a;
   int cen_cnt_b, cset_cnt_b, first_b, last_b, cset_cyc_b;
   logic [3:0] first_nib_b, last_nib_b;

   always @(negedge clk) begin
      if (!rst) begin
         if (cen_a) begin
            check("a_cen_expected", cen_a, q_a.size() > 0);
            if (q_a.size() > 0) check("a_cfg_shift", cs_a, q_a.pop_front());
            check("a_cset_during_cen", cset_a, 1'b0);
            if (cen_cnt_a == 0) first_a = cyc;
            last_a = cyc;
            cen_cnt_a++;
         end
         if (cset_a) begin
            cset_cnt_a++;
            cset_cyc_a = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (cen_b) begin
            check("b_cen_expected", cen_b, q_b.size() > 0);
            if (q_b.size() > 0) check("b_cfg_shift", cs_b, q_b.pop_front());
            if (cen_cnt_b == 0) begin
               first_b = cyc;
               first_nib_b = cs_b;
            end
            last_b = cyc;
            last_nib_b = cs_b;
            cen_cnt_b++;
         end
         if (cset_b) begin
            cset_cnt_b++;
            cset_cyc_b = cyc;
         end
      end
   end

   // Called on a negedge; holds valid low for `stall` ready cycles, then transfers one word.
   task automatic send_a(input logic [7:0] w, input int stall);
      int t = 0;
      int s = stall;
      while (s > 0 && t < 100) begin
         if (dr_a) s--;
         @(negedge clk);
         t++;
      end
      din_a = w;
      dv_a = 1'b1;
      while (!dr_a && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("a_ready_timeout", dr_a, 1'b1);
      @(negedge clk);
      dv_a = 1'b0;
      din_a = '0;
   endtask

   task automatic send_b(input logic [31:0] w);
      int t = 0;
      din_b = w;
      dv_b = 1'b1;
      while (!dr_b && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("b_ready_timeout", dr_b, 1'b1);
      @(negedge clk);
      dv_b = 1'b0;
      din_b = '0;
   endtask

   task automatic run_a(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                        input bit glitch, input logic [9:0] exp_bits, input string tag);
      bit exp_done;
      int t;
`ifdef CFG_LOADER_CRC_EN
      logic [15:0] crc;
`endif
      for (int i = 0; i < 10; i++) q_a.push_back(exp_bits[i]);
      cen_cnt_a = 0;
      cset_cnt_a = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      send_a(w0, 0);
      if (glitch) begin
         start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
      end
      send_a(w1, stall);
`ifdef CFG_LOADER_CRC_EN
      crc = 16'hFFFF;
      for (int i = 0; i < 10; i++) crc = crc_bit(crc, exp_bits[i]);
      send_a(crc[7:0], 0);
      exp_done = (crc[15:8] == 8'h00);
`else
      exp_done = 1'b1;
`endif
      t = 0;
      while (!(done_a || err_a) && t < 60) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_cen_count"}, cen_cnt_a, 10);
      check({tag, "_cen_span"}, last_a - first_a + 1, 10 + stall);
      check({tag, "_queue_left"}, q_a.size(), 0);
      check({tag, "_cset_count"}, cset_cnt_a, exp_done ? 1 : 0);
`ifndef CFG_LOADER_CRC_EN
      check({tag, "_cset_timing"}, cset_cyc_a, last_a + 1);
`endif
      check({tag, "_done_en_err_busy_rdy"}, {done_a, en_a, err_a, busy_a, dr_a},
            {exp_done, exp_done, !exp_done, 1'b0, 1'b0});
   endtask

   task automatic run_b(input logic [31:0] w, input bit flip, input string tag);
      bit exp_done;
      int t;
`ifdef CFG_LOADER_CRC_EN
      logic [15:0] crc;
`endif
      for (int k = 0; k < 8; k++) q_b.push_back(w[4*k +: 4]);
      cen_cnt_b = 0;
      cset_cnt_b = 0;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      send_b(w);
`ifdef CFG_LOADER_CRC_EN
      crc = 16'hFFFF;
      for (int i = 0; i < 32; i++) crc = crc_bit(crc, w[i]);
      send_b({16'h0000, crc ^ (flip ? 16'h0100 : 16'h0000)});
      exp_done = !flip;
`else
      exp_done = 1'b1;
`endif
      t = 0;
      while (!(done_b || err_b) && t < 60) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_cen_count"}, cen_cnt_b, 8);
      check({tag, "_cen_span"}, last_b - first_b + 1, 8);
      check({tag, "_cset_count"}, cset_cnt_b, exp_done ? 1 : 0);
`ifndef CFG_LOADER_CRC_EN
      check({tag, "_cset_timing"}, cset_cyc_b, last_b + 1);
`endif
      check({tag, "_done_en_err_busy"}, {done_b, en_b, err_b, busy_b},
            {exp_done, exp_done, !exp_done, 1'b0});
   endtask

   typedef struct {
      logic [7:0] w0;
      logic [7:0] w1;
      int         stall;
      bit         glitch;
      logic [9:0] exp_bits;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int t;
      vecs[0] = '{w0: 8'hBE, w1: 8'h02, stall: 0, glitch: 1'b0, exp_bits: 10'h2BE};
      vecs[1] = '{w0: 8'h00, w1: 8'hFF, stall: 0, glitch: 1'b0, exp_bits: 10'h300};
      vecs[2] = '{w0: 8'hBE, w1: 8'h02, stall: 3, glitch: 1'b0, exp_bits: 10'h2BE};
      vecs[3] = '{w0: 8'hA5, w1: 8'hFD, stall: 0, glitch: 1'b1, exp_bits: 10'h1A5};
      vecs[4] = '{w0: 8'hFF, w1: 8'h00, stall: 2, glitch: 1'b1, exp_bits: 10'h0FF};

      repeat (3) @(negedge clk);
      check("a_reset_outputs", {cen_a, cset_a, en_a, busy_a, done_a, err_a, cs_a, dr_a}, 0);
      check("b_reset_outputs", {cen_b, cset_b, en_b, busy_b, done_b, err_b, cs_b, dr_b}, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_a(vecs[i].w0, vecs[i].w1, vecs[i].stall, vecs[i].glitch, vecs[i].exp_bits,
               $sformatf("a_vec%0d", i));
      end

      run_b(32'hCAFEBABE, 1'b0, "b_cafebabe");
      check("b_cycle0_slice", first_nib_b, 4'hE);
      check("b_cycle7_slice", last_nib_b, 4'hC);
      run_b(32'h12345678, 1'b1, "b_second");
      check("b_second_cycle0_slice", first_nib_b, 4'h8);

      // Reset during shift cycle 5 of a single-chain load.
      q_a.delete();
      for (int i = 0; i < 10; i++) q_a.push_back(vecs[0].exp_bits[i]);
      cen_cnt_a = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      send_a(8'hBE, 0);
      t = 0;
      while (cen_cnt_a < 6 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("a_reached_cycle5", cen_cnt_a, 6);
      rst = 1'b1;
      @(negedge clk);
      check("a_midshift_reset_outputs", {cen_a, cset_a, en_a, busy_a, done_a, err_a, cs_a, dr_a}, 0);
      check("b_midshift_reset_outputs", {cen_b, cset_b, en_b, busy_b, done_b, err_b, cs_b, dr_b}, 0);
      rst = 1'b0;
      q_a.delete();
      run_a(vecs[0].w0, vecs[0].w1, 0, 1'b0, vecs[0].exp_bits, "a_restart");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter NUM_CHAINS, default 1: number of parallel configuration shift chains driven.
REQ-002 Parameter CHAIN_LEN, default 4768: bits per chain, equal to the shift cycles per load; minimum 1.
REQ-003 Parameter WORD_W, default 32: input word width; SHALL be a multiple of NUM_CHAINS, else elaboration error.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: one-cycle request to begin a load.
REQ-007 Ports data_in/data_valid/data_ready, input/input/output, WORD_W/1/1: bitstream word stream; transfer when valid&&ready.
REQ-008 Port cfg_shift, output, NUM_CHAINS: serial bit per chain (bit i to chain i shift_in).
REQ-009 Ports cen/cset/en, output, 1 each: tile shift-enable, config-latch pulse, tile run enable.
REQ-010 Ports busy/done/err, output, 1 each: load in progress, load complete, CRC failure.

Function
REQ-011 FSM states IDLE, SHIFT, CHECK, SET, DONE, ERR; CHECK exists only with CFG_LOADER_CRC_EN.
REQ-012 IDLE/DONE/ERR + start -> SHIFT next cycle; start in SHIFT/CHECK/SET ignored.
REQ-013 Words consumed LSB first; each shift cycle emits next NUM_CHAINS bits, bit k of slice to cfg_shift[k]; one word spans WORD_W/NUM_CHAINS cycles.
REQ-014 cen high exactly on cycles where cfg_shift carries a valid slice; no buffered word -> cen low (stall), counters hold.
REQ-015 Single-word buffer; data_ready high in SHIFT/CHECK when buffer empty or last slice emitted this cycle; back-to-back words give gapless cen.
REQ-016 After CHAIN_LEN cen cycles: -> SET (or CHECK with CRC); excess bits of final word discarded.
REQ-017 SET: cset high exactly one cycle, cen low; -> DONE.
REQ-018 DONE: done=1, en=1 until start or rst; busy=1 in SHIFT/CHECK/SET only.
REQ-019 Words required = ceil(CHAIN_LEN*NUM_CHAINS/WORD_W); data_ready low outside SHIFT/CHECK.
REQ-020 Shift counter width clog2(CHAIN_LEN+1); no wrap within a load.

Reset
REQ-021 rst (any state, incl. mid-shift) -> IDLE next edge; cen, cset, en, busy, done, err, cfg_shift, data_ready = 0; buffer emptied, counters 0.
REQ-022 Partially shifted chains after rst are not cleared; a fresh start reloads fully.

Configuration
REQ-023 Macro CFG_LOADER_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over all shifted bits in emission order (cycle order, chain 0 first).
REQ-024 With it: CHECK accepts one extra word; low 16 bits == CRC -> SET; mismatch -> ERR, err=1, no cset, en=0, until start/rst.
REQ-025 Without it: no CRC word, CHECK/ERR absent, err tied 0.

Structure
REQ-026 Package cfg_loader_pkg: state enum, CRC_POLY, CRC_INIT, CRC_W=16.
REQ-027 Sub-module cfg_crc16 (NUM_CHAINS bits/cycle update), instantiated only under CFG_LOADER_CRC_EN.

Verification
REQ-028 NUM_CHAINS=1, CHAIN_LEN=10, WORD_W=8; words 0xBE,0x02 -> cfg_shift 0,1,1,1,1,1,0,1,0,1 over 10 cen cycles, cset 1 cycle after, done/en high.
REQ-029 NUM_CHAINS=4, CHAIN_LEN=8, WORD_W=32; word 0xCAFEBABE -> cycle0 cfg_shift=0xE, cycle7 0xC; cset next cycle.
REQ-030 data_valid dropped 3 cycles mid-load -> cen low exactly 3 cycles, output stream identical to unstalled run.
REQ-031 rst asserted at shift cycle 5 -> all outputs 0 next edge; restart yields full 10-cycle load.
REQ-032 CRC_EN: correct CRC word -> cset, done; flipped CRC bit -> err=1, cset never, en=0.
REQ-033 start pulsed during SHIFT -> ignored; cen count still exactly CHAIN_LEN.
